// File: rtl/pwm_decoder_pkg.sv
// pwm_decoder_pkg: shared width, FSM state encoding and majority helper for the PWM decoder
package pwm_decoder_pkg;
  localparam int PWM_WIDTH = 10;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MEASURE = 2'd1, ST_FLAT = 2'd2} state_e;
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: PWM input and decoded-value outputs of the decoder
interface pwm_decoder_if #(parameter int WIDTH = 10);
  logic             pwm_in;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             err;
  logic             sat;
  logic             locked;
  modport master (output pwm_in, input value, valid, err, sat, locked);
  modport slave  (input pwm_in, output value, valid, err, sat, locked);
endinterface

// File: rtl/pwm_in_cond.sv
// pwm_in_cond: synchronizer, optional majority deglitch (DEGLITCH_EN) and rise detect for pwm_in
module pwm_in_cond import pwm_decoder_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise
);
  logic [1:0] sync_q;
  logic       s_q, s_prev_q, s_in;
`ifdef DEGLITCH_EN
  logic [2:0] hist_q;
  always_ff @(posedge clk)
    if (!rst_n) hist_q <= '0;
    else hist_q <= {hist_q[1:0], sync_q[1]};
  assign s_in = maj3(hist_q);
`else
  assign s_in = sync_q[1];
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync_q   <= '0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pwm_in};
      s_q      <= s_in;
      s_prev_q <= s_q;
    end
  assign s    = s_q;
  assign rise = s_q & ~s_prev_q;
endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers a WIDTH-bit sample from the duty cycle of 2**WIDTH-clock PWM frames
module pwm_decoder import pwm_decoder_pkg::*; #(
  parameter int WIDTH = PWM_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  pwm_decoder_if.slave bus
);
  localparam logic [WIDTH:0]   P   = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX = '1;
  state_e           state_q, state_d;
  logic [WIDTH:0]   per_q, per_d, hi_q, hi_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d, err_q, err_d, sat_q, sat_d;
  logic             s, rise, full, meas;
  pwm_in_cond u_cond (.clk(clk), .rst_n(rst_n), .pwm_in(bus.pwm_in), .s(s), .rise(rise));
  assign full = per_q == P;
  assign meas = state_q == ST_MEASURE;
  // A rise always restarts the frame; a full frame without one falls into FLAT and emits.
  always_comb begin
    state_d = state_q;
    per_d   = per_q + ONE;
    hi_d    = hi_q;
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    sat_d   = sat_q;
    if (rise) begin
      state_d = ST_MEASURE;
      per_d   = ONE;
      hi_d    = ONE;
      valid_d = meas & full;
      err_d   = meas & ~full;
      value_d = meas & full ? hi_q[WIDTH-1:0] : value_q;
      sat_d   = meas & full ? 1'b0 : sat_q;
    end else if (full) begin
      state_d = ST_FLAT;
      per_d   = ONE;
      valid_d = 1'b1;
      value_d = meas ? (hi_q == P ? MAX : hi_q[WIDTH-1:0]) : {WIDTH{s}};
      sat_d   = meas ? hi_q == P : s;
    end else if (meas) begin
      hi_d = hi_q + {{WIDTH{1'b0}}, s};
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      per_q   <= '0;
      hi_q    <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
    end
  assign bus.value  = value_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.sat    = sat_q;
  assign bus.locked = meas;
endmodule
